// File: rtl/riscv_mc_mem_port_pkg.sv
// Shared types and helpers for the multicycle memory port.
// Contents:
//   memport_state_t : FSM states of the port
//   mem_size_t      : access size decoded from funct3[1:0]
//   fault_cause_t   : encoding reported on core_fault_cause
//   F3_*            : RISC-V load/store funct3 values
//   f3_size / f3_legal / f3_misaligned : access decode helpers
package riscv_mc_mem_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } memport_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_cause_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Size lives in the low two funct3 bits for every load/store encoding.
  function automatic mem_size_t f3_size(input logic [2:0] f3);
    return mem_size_t'(f3[1:0]);
  endfunction

  // Unsigned variants exist only for loads; 64-bit forms only on a wide core.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3, input logic wide);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = ~we;
      F3_LD:               ok = wide;
      F3_LWU:              ok = wide & ~we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] low);
    logic bad;
    case (f3_size(f3))
      SZ_HALF:   bad = low[0];
      SZ_WORD:   bad = |low[1:0];
      SZ_DOUBLE: bad = |low;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_mc_mem_port_fmt.sv
// mem_lane_fmt: purely combinational lane formatter.
// Stores: replicates the right-justified store data across all byte lanes and
// builds byte enables from size and the low address bits.
// Loads: shifts the bus word down to the addressed byte and sign/zero extends.
// Ports:
//   funct3     in  access funct3
//   off        in  address bits below the bus lane granule
//   wdata      in  right-justified store data
//   rdata      in  raw bus read data
//   lane_wdata out replicated store data
//   byteen     out byte enables
//   load_data  out aligned/extended load result
module mem_lane_fmt
  import riscv_mc_mem_port_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]               funct3,
  input  logic [$clog2(WIDTH/8)-1:0] off,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH-1:0]         rdata,
  output logic [WIDTH-1:0]         lane_wdata,
  output logic [WIDTH/8-1:0]       byteen,
  output logic [WIDTH-1:0]         load_data
);

  localparam int NB = WIDTH / 8;

  mem_size_t         size;
  logic [NB-1:0]     base_en;
  logic [WIDTH-1:0]  shifted;

  assign size = f3_size(funct3);

  // Lane gi carries the store byte whose index repeats with the access size.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_wdata[gi*8 +: 8] =
          (size == SZ_BYTE) ? wdata[7:0] :
          (size == SZ_HALF) ? wdata[(gi%2)*8 +: 8] :
          (size == SZ_WORD) ? wdata[(gi%4)*8 +: 8] :
                              wdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    case (size)
      SZ_BYTE: base_en = NB'(1'b1);
      SZ_HALF: base_en = NB'(2'b11);
      SZ_WORD: base_en = NB'(4'hF);
      default: base_en = '1;
    endcase
    byteen = base_en << off;
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    case (funct3)
      F3_LB:   load_data = WIDTH'($signed(shifted[7:0]));
      F3_LH:   load_data = WIDTH'($signed(shifted[15:0]));
      F3_LW:   load_data = WIDTH'($signed(shifted[31:0]));
      F3_LBU:  load_data = WIDTH'(shifted[7:0]);
      F3_LHU:  load_data = WIDTH'(shifted[15:0]);
      F3_LWU:  load_data = WIDTH'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_mc_mem_port.sv
// riscv_mc_mem_port: memory port of the multicycle core. Accepts one access
// from the datapath, runs it over a req/gnt/rvalid bus, stalls the core while
// outstanding and reports completion or a fault.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   core_req/we/addr/wdata/funct3  access from the core (sampled in IDLE)
//   core_busy                  port not idle
//   core_done / core_fault     one-cycle completion / error pulses
//   core_rdata                 formatted load result, held until next load
//   core_fault_cause           cause of the last fault, held until next accept
//   bus_req/we/addr/wdata/byteen   bus request, stable until bus_gnt
//   bus_gnt/rvalid/rdata       bus responses
module riscv_mc_mem_port
  import riscv_mc_mem_port_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [WIDTH-1:0]   core_addr,
  input  logic [WIDTH-1:0]   core_wdata,
  input  logic [2:0]         core_funct3,
  output logic               core_busy,
  output logic               core_done,
  output logic [WIDTH-1:0]   core_rdata,
  output logic               core_fault,
  output logic [1:0]         core_fault_cause,
  output logic               bus_req,
  output logic               bus_we,
  output logic [WIDTH-1:0]   bus_addr,
  output logic [WIDTH-1:0]   bus_wdata,
  output logic [WIDTH/8-1:0] bus_byteen,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [WIDTH-1:0]   bus_rdata
);

  localparam int   NB    = WIDTH / 8;
  localparam int   OFF_W = $clog2(NB);
  localparam int   CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic WIDE  = (WIDTH == 64);
  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT);

  memport_state_t   state_reg;
  fault_cause_t     cause_reg;
  logic             we_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [2:0]       f3_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rdata_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fault_reg;
  logic             req_reg;

  logic [WIDTH-1:0] fmt_wdata;
  logic [NB-1:0]    fmt_byteen;
  logic [WIDTH-1:0] fmt_load;
  logic             acc_illegal;
  logic             acc_misaligned;
  logic [CNT_W:0]   cnt_inc;
  logic             timed_out;

  mem_lane_fmt #(.WIDTH(WIDTH)) u_fmt (
    .funct3     (f3_reg),
    .off        (addr_reg[OFF_W-1:0]),
    .wdata      (wdata_reg),
    .rdata      (bus_rdata),
    .lane_wdata (fmt_wdata),
    .byteen     (fmt_byteen),
    .load_data  (fmt_load)
  );

  // Legality is judged on the live core inputs so the fault decision is made
  // in the same edge that captures the access.
  assign acc_illegal    = ~f3_legal(core_we, core_funct3, WIDE);
  assign acc_misaligned = f3_misaligned(core_funct3, 3'(core_addr[OFF_W-1:0]));

  // The cycle whose increment would reach TIMEOUT is the last one allowed.
  assign cnt_inc   = {1'b0, cnt_reg} + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cause_reg <= FC_NONE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      f3_reg    <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      req_reg   <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (core_req) begin
            we_reg    <= core_we;
            addr_reg  <= core_addr;
            wdata_reg <= core_wdata;
            f3_reg    <= core_funct3;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            if (acc_illegal) begin
              cause_reg <= FC_ILLEGAL;
              fault_reg <= 1'b1;
              state_reg <= ST_FAULT;
            end else if (acc_misaligned) begin
              cause_reg <= FC_MISALIGN;
              fault_reg <= 1'b1;
              state_reg <= ST_FAULT;
            end else begin
              cause_reg <= FC_NONE;
              req_reg   <= 1'b1;
              state_reg <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_reg <= cnt_inc[CNT_W-1:0];
          if (bus_gnt) begin
            req_reg <= 1'b0;
            if (we_reg) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_WAIT_R;
            end
          end else if (timed_out) begin
            req_reg   <= 1'b0;
            cause_reg <= FC_TIMEOUT;
            fault_reg <= 1'b1;
            state_reg <= ST_FAULT;
          end
        end
        ST_WAIT_R: begin
          cnt_reg <= cnt_inc[CNT_W-1:0];
          if (bus_rvalid) begin
            rdata_reg <= fmt_load;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else if (timed_out) begin
            cause_reg <= FC_TIMEOUT;
            fault_reg <= 1'b1;
            state_reg <= ST_FAULT;
          end
        end
        ST_DONE, ST_FAULT: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          req_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_busy        = busy_reg;
  assign core_done        = done_reg;
  assign core_fault       = fault_reg;
  assign core_rdata       = rdata_reg;
  assign core_fault_cause = cause_reg;

  // Bus payload is only presented while a request is pending.
  assign bus_req    = req_reg;
  assign bus_we     = req_reg & we_reg;
  assign bus_addr   = req_reg ? {addr_reg[WIDTH-1:OFF_W], OFF_W'(0)} : '0;
  assign bus_wdata  = (req_reg & we_reg) ? fmt_wdata : '0;
  assign bus_byteen = req_reg ? fmt_byteen : '0;

endmodule

// File: tb/tb_riscv_mc_mem_port.sv
module tb_riscv_mc_mem_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus, steered to one of two instances by sel64.
  bit          sel64;
  logic        drv_req, drv_we, drv_gnt, drv_rvalid;
  logic [2:0]  drv_f3;
  logic [63:0] drv_addr, drv_wdata, drv_rdata;

  logic        a_busy, a_done, a_fault, a_req, a_we;
  logic [1:0]  a_cause;
  logic [31:0] a_rdata, a_baddr, a_bwdata;
  logic [3:0]  a_be;

  logic        b_busy, b_done, b_fault, b_req, b_we;
  logic [1:0]  b_cause;
  logic [63:0] b_rdata, b_baddr, b_bwdata;
  logic [7:0]  b_be;

  riscv_mc_mem_port #(.WIDTH(32), .TIMEOUT(255)) u_dut32 (
    .clk(clk), .reset(reset),
    .core_req(drv_req & ~sel64), .core_we(drv_we), .core_addr(drv_addr[31:0]),
    .core_wdata(drv_wdata[31:0]), .core_funct3(drv_f3),
    .core_busy(a_busy), .core_done(a_done), .core_rdata(a_rdata),
    .core_fault(a_fault), .core_fault_cause(a_cause),
    .bus_req(a_req), .bus_we(a_we), .bus_addr(a_baddr), .bus_wdata(a_bwdata),
    .bus_byteen(a_be), .bus_gnt(drv_gnt & ~sel64), .bus_rvalid(drv_rvalid & ~sel64),
    .bus_rdata(drv_rdata[31:0])
  );

  riscv_mc_mem_port #(.WIDTH(64), .TIMEOUT(4)) u_dut64 (
    .clk(clk), .reset(reset),
    .core_req(drv_req & sel64), .core_we(drv_we), .core_addr(drv_addr),
    .core_wdata(drv_wdata), .core_funct3(drv_f3),
    .core_busy(b_busy), .core_done(b_done), .core_rdata(b_rdata),
    .core_fault(b_fault), .core_fault_cause(b_cause),
    .bus_req(b_req), .bus_we(b_we), .bus_addr(b_baddr), .bus_wdata(b_bwdata),
    .bus_byteen(b_be), .bus_gnt(drv_gnt & sel64), .bus_rvalid(drv_rvalid & sel64),
    .bus_rdata(drv_rdata)
  );

  logic        o_busy, o_done, o_fault, o_req, o_we;
  logic [1:0]  o_cause;
  logic [63:0] o_rdata, o_baddr, o_bwdata;
  logic [7:0]  o_be;

  always_comb begin
    if (sel64) begin
      o_busy = b_busy; o_done = b_done; o_fault = b_fault; o_req = b_req; o_we = b_we;
      o_cause = b_cause; o_rdata = b_rdata; o_baddr = b_baddr; o_bwdata = b_bwdata; o_be = b_be;
    end else begin
      o_busy = a_busy; o_done = a_done; o_fault = a_fault; o_req = a_req; o_we = a_we;
      o_cause = a_cause; o_rdata = {32'h0, a_rdata}; o_baddr = {32'h0, a_baddr};
      o_bwdata = {32'h0, a_bwdata}; o_be = {4'h0, a_be};
    end
  end

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [63:0] rdata;
    bit          chk_rdata;
    int          lat;
    int          req_cycles;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, plays the bus side, and pops the scoreboard entry when
  // the port reports completion or a fault.
  task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input int gnt_wait, input int rv_wait, input logic [63:0] rdata,
                            input bit chk_bus, input logic [63:0] exp_baddr,
                            input logic [7:0] exp_be, input logic [63:0] exp_bwdata,
                            input logic exp_fault, input logic [1:0] exp_cause,
                            input logic [63:0] exp_rdata, input int exp_lat, input int exp_reqc);
    exp_t e;
    int cyc, reqc, waitc, busy_gaps;
    bit granted, finished;
    e.fault = exp_fault; e.cause = exp_cause; e.rdata = exp_rdata;
    e.chk_rdata = !we && !exp_fault; e.lat = exp_lat; e.req_cycles = exp_reqc;
    sb.push_back(e);
    drv_req = 1'b1; drv_we = we; drv_f3 = f3; drv_addr = addr; drv_wdata = wdata;
    step();
    drv_req = 1'b0; drv_we = 1'b0; drv_addr = '0; drv_wdata = '0; drv_f3 = '0;
    cyc = 1; reqc = 0; waitc = 0; busy_gaps = 0; granted = 0; finished = 0;
    while (!finished && cyc < 60) begin
      drv_gnt = 1'b0; drv_rvalid = 1'b0;
      if (o_done || o_fault) begin
        finished = 1;
        e = sb.pop_front();
        vectors++;
        if (o_fault !== e.fault) begin
          miscompares++;
          $display("FAIL %s.fault got=%0b exp=%0b", name, o_fault, e.fault);
        end
        vectors++;
        if (o_cause !== e.cause) begin
          miscompares++;
          $display("FAIL %s.cause got=%0b exp=%0b", name, o_cause, e.cause);
        end
        if (e.chk_rdata) begin
          vectors++;
          if (o_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL %s.rdata got=%h exp=%h", name, o_rdata, e.rdata);
          end
        end
        vectors++;
        if (cyc != e.lat) begin
          miscompares++;
          $display("FAIL %s.latency got=%0d exp=%0d", name, cyc, e.lat);
        end
        vectors++;
        if (reqc != e.req_cycles) begin
          miscompares++;
          $display("FAIL %s.req_cycles got=%0d exp=%0d", name, reqc, e.req_cycles);
        end
      end else begin
        if (!o_busy) busy_gaps++;
        if (o_req) begin
          if (chk_bus) begin
            vectors++;
            if (o_baddr !== exp_baddr || o_we !== we) begin
              miscompares++;
              $display("FAIL %s.bus_addr got=%h/%0b exp=%h/%0b", name, o_baddr, o_we, exp_baddr, we);
            end
            if (we) begin
              vectors++;
              if (o_be !== exp_be || o_bwdata !== exp_bwdata) begin
                miscompares++;
                $display("FAIL %s.bus_store got=%h/%h exp=%h/%h", name, o_be, o_bwdata, exp_be, exp_bwdata);
              end
            end
          end
          if (reqc == gnt_wait) begin drv_gnt = 1'b1; granted = 1; end
          reqc++;
        end else if (granted && !we) begin
          if (waitc == rv_wait) begin drv_rvalid = 1'b1; drv_rdata = rdata; end
          waitc++;
        end
        step();
        cyc++;
      end
    end
    drv_gnt = 1'b0; drv_rvalid = 1'b0; drv_rdata = '0;
    if (!finished) begin
      void'(sb.pop_front());
      vectors++; miscompares++;
      $display("FAIL %s.completion got=none exp=done_or_fault within 60 cycles", name);
    end else begin
      vectors++;
      if (busy_gaps != 0) begin
        miscompares++;
        $display("FAIL %s.busy got=%0d idle cycles exp=0", name, busy_gaps);
      end
      step();
      vectors++;
      if (o_done !== 1'b0 || o_fault !== 1'b0 || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s.pulse got=done%0b fault%0b busy%0b exp=000", name, o_done, o_fault, o_busy);
      end
      if (exp_fault) begin
        vectors++;
        if (o_cause !== exp_cause) begin
          miscompares++;
          $display("FAIL %s.cause_held got=%0b exp=%0b", name, o_cause, exp_cause);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    vectors++;
    if ({a_busy, a_done, a_fault, a_req, a_we, a_cause, a_be} !== '0 ||
        {a_rdata, a_baddr, a_bwdata} !== '0) begin
      miscompares++;
      $display("FAIL reset32 got=%b/%h exp=0", {a_busy, a_done, a_fault, a_req, a_we, a_cause, a_be}, a_rdata);
    end
    vectors++;
    if ({b_busy, b_done, b_fault, b_req, b_we, b_cause, b_be} !== '0 ||
        {b_rdata, b_baddr, b_bwdata} !== '0) begin
      miscompares++;
      $display("FAIL reset64 got=%b/%h exp=0", {b_busy, b_done, b_fault, b_req, b_we, b_cause, b_be}, b_rdata);
    end
  endtask

  task automatic test_store32();
    sel64 = 0;
    run_access("sw_104", 1, 3'b010, 64'h104, 64'hDEADBEEF, 0, 0, 0,
               1, 64'h104, 8'h0F, 64'hDEADBEEF, 0, 2'b00, 0, 2, 1);
    run_access("sh_202", 1, 3'b001, 64'h202, 64'h0000ABCD, 0, 0, 0,
               1, 64'h200, 8'h0C, 64'hABCDABCD, 0, 2'b00, 0, 2, 1);
    run_access("sb_101_gnt3", 1, 3'b000, 64'h101, 64'h000000A5, 2, 0, 0,
               1, 64'h100, 8'h02, 64'hA5A5A5A5, 0, 2'b00, 0, 4, 3);
  endtask

  task automatic test_load32();
    sel64 = 0;
    run_access("lb_103", 0, 3'b000, 64'h103, 0, 0, 3, 64'h80FF1234,
               1, 64'h100, 0, 0, 0, 2'b00, 64'hFFFFFF80, 6, 1);
    run_access("lbu_103", 0, 3'b100, 64'h103, 0, 0, 3, 64'h80FF1234,
               1, 64'h100, 0, 0, 0, 2'b00, 64'h00000080, 6, 1);
    run_access("lhu_102", 0, 3'b101, 64'h102, 0, 1, 0, 64'h80017F00,
               1, 64'h100, 0, 0, 0, 2'b00, 64'h00008001, 4, 2);
    run_access("lh_102", 0, 3'b001, 64'h102, 0, 0, 0, 64'h80017F00,
               1, 64'h100, 0, 0, 0, 2'b00, 64'hFFFF8001, 3, 1);
  endtask

  task automatic test_faults32();
    sel64 = 0;
    run_access("lh_201_mis", 0, 3'b001, 64'h201, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 0);
    run_access("f3_011_w32", 0, 3'b011, 64'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0);
    run_access("f3_011_mis", 0, 3'b011, 64'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0);
    run_access("f3_111", 0, 3'b111, 64'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0);
    run_access("sbu_illegal", 1, 3'b100, 64'h100, 64'h11, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 0);
  endtask

  task automatic test_wide64();
    sel64 = 1;
    run_access("ld_8", 0, 3'b011, 64'h8, 0, 0, 0, 64'h8000000000000001,
               1, 64'h8, 0, 0, 0, 2'b00, 64'h8000000000000001, 3, 1);
    run_access("lwu_c", 0, 3'b110, 64'hC, 0, 0, 0, 64'h80000000_12345678,
               1, 64'h8, 0, 0, 0, 2'b00, 64'h0000000080000000, 3, 1);
    run_access("lw_c", 0, 3'b010, 64'hC, 0, 0, 0, 64'h80000000_12345678,
               1, 64'h8, 0, 0, 0, 2'b00, 64'hFFFFFFFF80000000, 3, 1);
    run_access("sd_10", 1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 0, 0, 0,
               1, 64'h10, 8'hFF, 64'h0123456789ABCDEF, 0, 2'b00, 0, 2, 1);
    run_access("sw_4", 1, 3'b010, 64'h4, 64'h00000000CAFEF00D, 0, 0, 0,
               1, 64'h0, 8'hF0, 64'hCAFEF00DCAFEF00D, 0, 2'b00, 0, 2, 1);
    run_access("sb_5", 1, 3'b000, 64'h5, 64'h5A, 0, 0, 0,
               1, 64'h0, 8'h20, 64'h5A5A5A5A5A5A5A5A, 0, 2'b00, 0, 2, 1);
    run_access("ld_4_mis", 0, 3'b011, 64'h4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 0);
  endtask

  task automatic test_timeout();
    sel64 = 1;
    run_access("to_nogrant", 1, 3'b010, 64'h20, 64'h1, 100, 0, 0,
               1, 64'h20, 8'h0F, 64'h0000000100000001, 1, 2'b11, 0, 5, 4);
    run_access("after_to", 1, 3'b010, 64'h24, 64'h2, 0, 0, 0,
               1, 64'h20, 8'hF0, 64'h0000000200000002, 0, 2'b00, 0, 2, 1);
    run_access("gnt_4th", 1, 3'b010, 64'h28, 64'h3, 3, 0, 0,
               1, 64'h28, 8'h0F, 64'h0000000300000003, 0, 2'b00, 0, 5, 4);
    run_access("to_norvalid", 0, 3'b011, 64'h30, 0, 0, 100, 0,
               1, 64'h30, 0, 0, 1, 2'b11, 0, 5, 1);
    run_access("rv_at_limit", 0, 3'b011, 64'h30, 0, 0, 2, 64'h0BADF00D0BADF00D,
               1, 64'h30, 0, 0, 0, 2'b00, 64'h0BADF00D0BADF00D, 5, 1);
  endtask

  task automatic test_reset_wait();
    sel64 = 0;
    drv_req = 1'b1; drv_we = 1'b0; drv_f3 = 3'b010; drv_addr = 64'h40;
    step();
    drv_req = 1'b0; drv_gnt = 1'b1;
    step();
    drv_gnt = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait.pre got=busy%0b req%0b exp=busy1 req0", o_busy, o_req);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({o_busy, o_done, o_fault, o_req, o_cause} !== '0 || o_rdata !== '0) begin
      miscompares++;
      $display("FAIL rst_wait.outputs got=%b/%h exp=0", {o_busy, o_done, o_fault, o_req, o_cause}, o_rdata);
    end
    drv_rvalid = 1'b1; drv_rdata = 64'h12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rdata !== '0) begin
        miscompares++;
        $display("FAIL rst_wait.stray_rvalid got=done%0b busy%0b rdata=%h exp=0", o_done, o_busy, o_rdata);
      end
    end
    drv_rvalid = 1'b0; drv_rdata = '0;
    run_access("after_rst", 0, 3'b010, 64'h40, 0, 0, 0, 64'hCAFE0001,
               1, 64'h40, 0, 0, 0, 2'b00, 64'hCAFE0001, 3, 1);
  endtask

  initial begin
    sel64 = 0; reset = 1'b1;
    drv_req = 0; drv_we = 0; drv_gnt = 0; drv_rvalid = 0;
    drv_f3 = '0; drv_addr = '0; drv_wdata = '0; drv_rdata = '0;
    test_reset();
    test_store32();
    test_load32();
    test_faults32();
    test_wide64();
    test_timeout();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/riscv_mc_mem_port.md
Name: riscv_mc_mem_port

Overview:
- Memory port unit for the next-generation multicycle core. Sits between the datapath's memory strobes and a variable-latency bus with a request/grant/response handshake.
- Stalls the core while a transfer is outstanding.
- Formats store lanes and byte enables, and aligns and extends load data per funct3.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
WIDTH, 32, data/address width; legal values 32 or 64; bus has WIDTH/8 byte lanes.
TIMEOUT, 255, max cycles in REQ+WAIT_R before bus fault; 0 disables timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_req  in  1  access request; sampled only in IDLE
core_we  in  1  1=store, 0=load
core_addr  in  WIDTH  byte address
core_wdata  in  WIDTH  store data, right-justified
core_funct3  in  3  RISC-V load/store funct3
core_busy  out  1  port not in IDLE; core must hold its FSM
core_done  out  1  one-cycle completion pulse
core_rdata  out  WIDTH  aligned/extended load result; valid while core_done=1, held until next load completes
core_fault  out  1  one-cycle pulse instead of core_done on error
core_fault_cause  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; held until next acceptance
bus_req  out  1  request valid; held until bus_gnt
bus_we  out  1  write strobe
bus_addr  out  WIDTH  lane-aligned address (low log2(WIDTH/8) bits zero)
bus_wdata  out  WIDTH  lane-replicated store data
bus_byteen  out  WIDTH/8  byte enables
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  WIDTH  read data

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- Reset in any state returns to IDLE at that edge and drops bus_req. A bus_rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT_R, DONE, FAULT.
- IDLE: on core_req, capture we/addr/wdata/funct3 into registers and check the access.
  - Illegal access -> FAULT with no bus activity.
  - Legal access -> REQ.
- REQ: bus_req=1; all bus_* outputs are driven from the captured registers and stay stable until grant.
  - On bus_gnt: store -> DONE; load -> WAIT_R.
- WAIT_R: on bus_rvalid, register the formatted load into core_rdata -> DONE.
- DONE: core_done=1 for exactly one cycle -> IDLE. Requests are not accepted in DONE.
- FAULT: core_fault=1 for exactly one cycle -> IDLE.
- core_busy = (state != IDLE).
- bus_rvalid outside WAIT_R is ignored. bus_gnt outside REQ is ignored.
- Minimum latency from core_req edge to core_done high (gnt in first REQ cycle, rvalid in the following cycle): store 2 cycles, load 3 cycles.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - If the counter reaches TIMEOUT without completion -> FAULT with cause 11, and bus_req drops.
  - If completion and timeout occur in the same cycle, completion wins.
- Legality:
  - funct3 000/100 byte, 001/101 half and 010 word are always legal. 011 (LD/SD) and 110 (LWU) are legal only when WIDTH=64.
  - 111 is always illegal. Stores with funct3 bit2 set are illegal.
  - Illegal funct3 -> cause 10. This check takes priority over misalignment.
- Misalignment (cause 01): half with addr[0]=1; word with addr[1:0]!=0; double with addr[2:0]!=0.
- Stores:
  - off = addr low bits.
  - Byte: data[7:0] replicated on every lane; byteen = 1<<off.
  - Half: data[15:0] replicated; byteen = 2'b11<<off.
  - Word: data[31:0] replicated; byteen = 4'hF<<off.
  - Double: full data; byteen all ones.
- Loads: shift bus_rdata right by off*8, then sign-extend (000/001/010/011) or zero-extend (100/101/110) to WIDTH.

Decomposition:
- Shared package: memport_state_t enum; mem_size_t (BYTE/HALF/WORD/DOUBLE); fault_cause_t; funct3 localparams (F3_LB … F3_LWU).
- One combinational sub-module, mem_lane_fmt, holding the store replication/byteen and load align/extend logic. It is reused by the pipelined core later.
- The FSM, capture registers and timeout counter stay in the top module.

Test Plan:
1. WIDTH=32, SW addr 0x104 data 0xDEADBEEF, gnt in first REQ cycle -> bus_addr 0x104, byteen 1111, wdata 0xDEADBEEF; core_done 2 cycles after req; bus_req high for one cycle.
2. LB addr 0x103, rvalid rdata 0x80FF1234 after 3 wait cycles -> core_rdata 0xFFFFFF80; LBU on the same access -> 0x00000080; busy throughout, done exactly one cycle.
3. SH addr 0x202 data 0x0000ABCD -> byteen 1100, wdata 0xABCDABCD; then LH addr 0x201 -> fault cause 01, bus_req never asserts.
4. WIDTH=32, funct3 011 -> fault cause 10. WIDTH=64, LD addr 0x8, rdata 0x8000000000000001 -> core_rdata unchanged; LWU addr 0xC with upper word 0x80000000 -> 0x0000000080000000.
5. TIMEOUT=4, gnt never asserted -> bus_req drops and core_fault with cause 11 after 4 REQ cycles; next request is accepted normally. Variant: gnt in the 4th cycle -> completion, no fault.
6. Reset asserted in WAIT_R -> IDLE at next edge, outputs 0; a subsequent stray bus_rvalid produces no core_done.
